// File: rtl/input_pkg.sv
// Shared types and timing defaults for the input conditioner.
package input_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD_WAIT = 2'd1,
    REPEATING = 2'd2
  } rpt_state_e;

  // Defaults for the 65 MHz board clock: 10 ms debounce, 500 ms delay, 100 ms period.
  localparam int DEF_CHANNELS      = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 650000;
  localparam int DEF_REPEAT_DELAY  = 32500000;
  localparam int DEF_REPEAT_PERIOD = 6500000;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/conditioner_channel.sv
// One input channel: synchroniser, debounce counter, edge strobes and auto-repeat FSM.
module conditioner_channel
  import input_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clock,
  input  logic reset_n,
  input  logic noisy_i,
  input  logic repeat_en_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic press_o
);

  localparam int CW = cnt_width(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          stab_cnt_q, stab_cnt_d;
  logic [CW-1:0]          rpt_cnt_q, rpt_cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   press_q, press_d;
  rpt_state_e             state_q, state_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], noisy_i};
    stab_cnt_d = '0;
    clean_d    = clean_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    if (s != clean_q) begin
      if (stab_cnt_q == STABLE_LAST) begin
        clean_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        stab_cnt_d = stab_cnt_q + CW'(1);
      end
    end
  end

  // Fall wins over everything so a release never produces a late repeat press.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    press_d   = rise_d;
    if (fall_d) begin
      state_d   = RELEASED;
      rpt_cnt_d = '0;
    end else begin
      case (state_q)
        RELEASED: begin
          if (rise_d) begin
            state_d   = HELD_WAIT;
            rpt_cnt_d = '0;
          end
        end
        HELD_WAIT: begin
          if (!repeat_en_i) begin
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == DELAY_LAST) begin
            press_d   = 1'b1;
            rpt_cnt_d = '0;
            state_d   = REPEATING;
          end else begin
            rpt_cnt_d = rpt_cnt_q + CW'(1);
          end
        end
        REPEATING: begin
          if (!repeat_en_i) begin
            state_d   = HELD_WAIT;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == PERIOD_LAST) begin
            press_d   = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + CW'(1);
          end
        end
        default: begin
          state_d   = RELEASED;
          rpt_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q     <= '0;
      stab_cnt_q <= '0;
      rpt_cnt_q  <= '0;
      clean_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      press_q    <= 1'b0;
      state_q    <= RELEASED;
    end else begin
      sync_q     <= sync_d;
      stab_cnt_q <= stab_cnt_d;
      rpt_cnt_q  <= rpt_cnt_d;
      clean_q    <= clean_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      press_q    <= press_d;
      state_q    <= state_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign press_o = press_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel debounce with rise/fall strobes and per-channel auto-repeat press strobe.
module input_conditioner
  import input_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] noisy,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press
);

  if (CHANNELS < 1)      begin : g_bad_channels $error("CHANNELS must be >= 1"); end
  if (SYNC_STAGES < 2)   begin : g_bad_sync     $error("SYNC_STAGES must be >= 2"); end
  if (STABLE_CYCLES < 1) begin : g_bad_stable   $error("STABLE_CYCLES must be >= 1"); end
  if (REPEAT_DELAY < 1)  begin : g_bad_delay    $error("REPEAT_DELAY must be >= 1"); end
  if (REPEAT_PERIOD < 1) begin : g_bad_period   $error("REPEAT_PERIOD must be >= 1"); end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    conditioner_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clock      (clock),
      .reset_n    (reset_n),
      .noisy_i    (noisy[i]),
      .repeat_en_i(repeat_en[i]),
      .clean_o    (clean[i]),
      .rise_o     (rise[i]),
      .fall_o     (fall[i]),
      .press_o    (press[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short timing parameters.
module tb_input_conditioner;

  localparam int CH = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [CH-1:0] noisy;
  logic [CH-1:0] repeat_en;
  logic [CH-1:0] clean, rise, fall, press;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  input_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .noisy    (noisy),
    .repeat_en(repeat_en),
    .clean    (clean),
    .rise     (rise),
    .fall     (fall),
    .press    (press)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Step n cycles on channel ch; bit i of each mask is the output after step i.
  task automatic run_mask(input int n, input int ch, input int rel_at, input int en_at,
                          output logic [63:0] rise_m, output logic [63:0] fall_m,
                          output logic [63:0] press_m, output logic [63:0] clean_m);
    rise_m = '0; fall_m = '0; press_m = '0; clean_m = '0;
    for (int i = 1; i <= n; i++) begin
      if (i == rel_at) noisy[ch] = 1'b0;
      if (i == en_at)  repeat_en[ch] = 1'b1;
      step();
      rise_m[i]  = rise[ch];
      fall_m[i]  = fall[ch];
      press_m[i] = press[ch];
      clean_m[i] = clean[ch];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] rm, fm, pm, cm;
    logic [CH-1:0] acc;

    // Reset with all inputs high
    reset_n = 1'b0; noisy = 4'hF; repeat_en = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outputs", {48'd0, clean, rise, fall, press}, 64'd0);
    end
    reset_n = 1'b1;
    repeat (5) step();
    check("post_reset_clean_early", {60'd0, clean}, 64'h0);
    step();
    check("post_reset_clean", {60'd0, clean}, 64'hF);
    check("post_reset_rise", {60'd0, rise}, 64'hF);
    check("post_reset_press", {60'd0, press}, 64'hF);
    step();
    check("post_reset_rise_once", {60'd0, rise}, 64'h0);

    // Release all channels
    noisy = 4'h0;
    repeat (5) step();
    check("release_fall_early", {60'd0, fall}, 64'h0);
    step();
    check("release_fall", {60'd0, fall}, 64'hF);
    check("release_clean", {60'd0, clean}, 64'h0);

    // Glitch of 3 cycles on ch0 is rejected
    noisy[0] = 1'b1;
    run_mask(12, 0, 4, 0, rm, fm, pm, cm);
    check("glitch3_rise", rm, 64'd0);
    check("glitch3_press", pm, 64'd0);
    check("glitch3_clean", cm, 64'd0);

    // 4-cycle pulse passes
    noisy[0] = 1'b1;
    run_mask(14, 0, 5, 0, rm, fm, pm, cm);
    check("pulse4_rise", rm, 64'd1 << 6);
    check("pulse4_press", pm, 64'd1 << 6);
    check("pulse4_fall", fm, 64'd1 << 10);
    check("pulse4_clean", cm, 64'h3C0);

    // Auto-repeat on ch1: rise at step 6, held 30 cycles after rise
    repeat_en[1] = 1'b1; noisy[1] = 1'b1;
    run_mask(50, 1, 31, 0, rm, fm, pm, cm);
    check("repeat_rise", rm, 64'd1 << 6);
    check("repeat_press", pm, (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22) |
                              (64'd1 << 25) | (64'd1 << 28) | (64'd1 << 31) | (64'd1 << 34));
    check("repeat_fall", fm, 64'd1 << 36);

    // Repeat disabled, then enabled after offset 12
    repeat_en[1] = 1'b0; noisy[1] = 1'b1;
    run_mask(45, 1, 31, 19, rm, fm, pm, cm);
    check("norepeat_rise", rm, 64'd1 << 6);
    check("norepeat_press", pm, (64'd1 << 6) | (64'd1 << 28) | (64'd1 << 31) | (64'd1 << 34));
    check("norepeat_fall", fm, 64'd1 << 36);
    repeat_en[1] = 1'b0;

    // Simultaneous rise on ch2 and fall on ch3
    noisy[3] = 1'b1;
    repeat (8) step();
    check("simul_setup_clean", {60'd0, clean}, 64'h8);
    noisy[2] = 1'b1; noisy[3] = 1'b0;
    repeat (5) step();
    check("simul_early", {56'd0, rise, fall}, 64'h0);
    step();
    check("simul_rise", {60'd0, rise}, 64'h4);
    check("simul_fall", {60'd0, fall}, 64'h8);
    check("simul_clean", {60'd0, clean}, 64'h4);

    // Reset in the middle of a repeat sequence on ch1
    repeat_en[1] = 1'b1; noisy[1] = 1'b1;
    repeat (6) step();
    check("midreset_rise", {60'd0, rise}, 64'h2);
    repeat (10) step();
    check("midreset_press10", {60'd0, press}, 64'h2);
    reset_n = 1'b0;
    step();
    check("midreset_in_reset1", {48'd0, clean, rise, fall, press}, 64'd0);
    step();
    check("midreset_in_reset2", {48'd0, clean, rise, fall, press}, 64'd0);
    reset_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      acc = acc | rise | fall | press;
    end
    check("midreset_quiet", {60'd0, acc}, 64'h0);
    step();
    check("midreset_new_rise", {60'd0, rise}, 64'h6);
    check("midreset_new_press", {60'd0, press}, 64'h6);
    check("midreset_new_clean", {60'd0, clean}, 64'h6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
